fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle decode/control logic.
- Holds the program counter and issues requests to instruction memory over a req/gnt/rvalid interface.
- Presents the fetched instruction and its PC to decode with a valid/ready handshake.
- Computes the next PC from the branch decision (pc_src) and immediate (imm_op) that decode returns for the instruction being accepted.

---
 rtl/fetch_if.sv | 36 +++
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel plus the
// decode-side valid/ready channel with the branch feedback from decode.
// master = fetch unit, slave = memory/decode/redirect environment.
interface fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // memory side
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  // decode side
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_src;
  logic [ADDR_WIDTH-1:0] imm_op;
  // external redirect
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flush_addr;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, pc,
    input  mem_gnt, mem_rdata, mem_rvalid, instr_ready, pc_src, imm_op,
           flush, flush_addr
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, pc,
    output mem_gnt, mem_rdata, mem_rvalid, instr_ready, pc_src, imm_op,
           flush, flush_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one memory request at a time,
// hands the instruction to decode and computes the next PC from decode's
// branch decision. Flush redirects fetch from any state.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned targets raise a sticky
// misalign_err and park the FSM in HALT; without it target bits [1:0] are
// cleared.
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic     misalign_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_discard;   // response of a flushed request still due
  logic                  r_mem_req;
  logic                  r_instr_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc;

  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic [ADDR_WIDTH-1:0] w_br_pc;
  logic [ADDR_WIDTH-1:0] w_tgt_raw;
  logic [ADDR_WIDTH-1:0] w_tgt;
  logic [ADDR_WIDTH-1:0] w_flush_tgt;

  // Next-PC candidates; additions wrap modulo 2^ADDR_WIDTH.
  assign w_seq_pc  = r_pc + ADDR_WIDTH'(4);
  assign w_br_pc   = r_pc + bus.imm_op;
  assign w_tgt_raw = bus.pc_src ? w_br_pc : w_seq_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_halt;

  assign w_tgt       = w_tgt_raw;
  assign w_flush_tgt = bus.flush_addr;
  // Trap on a misaligned flush target, or a misaligned computed target at accept.
  assign w_halt = (r_state != S_HALT) &&
                  ((bus.flush && (bus.flush_addr[1:0] != 2'b00)) ||
                   (!bus.flush && (r_state == S_OUT) && bus.instr_ready &&
                    (w_tgt_raw[1:0] != 2'b00)));
  assign misalign_err = r_misalign;
`else
  assign w_tgt       = w_tgt_raw & LP_ALIGN_MASK;
  assign w_flush_tgt = bus.flush_addr & LP_ALIGN_MASK;
`endif

  // Fetch FSM with registered handshake outputs; flush outranks every event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_VECTOR;
      r_discard     <= 1'b0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_pc          <= RESET_VECTOR;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_halt) begin
        r_state       <= S_HALT;
        r_mem_req     <= 1'b0;
        r_instr_valid <= 1'b0;
        r_misalign    <= 1'b1;
      end else
`endif
      case (r_state)
        S_IDLE: begin
          r_state   <= S_REQ;
          r_mem_req <= 1'b1;
          if (bus.flush) r_fetch_pc <= w_flush_tgt;
        end
        S_REQ: begin
          if (bus.flush) begin
            r_fetch_pc <= w_flush_tgt;
            if (bus.mem_gnt) begin
              r_discard <= 1'b1;
              r_state   <= S_WAIT;
              r_mem_req <= 1'b0;
            end
          end else if (bus.mem_gnt) begin
            r_state   <= S_WAIT;
            r_mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            r_fetch_pc <= w_flush_tgt;
            if (bus.mem_rvalid) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
            end else begin
              r_discard <= 1'b1;
            end
          end else if (bus.mem_rvalid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
            end else begin
              r_instr       <= bus.mem_rdata;
              r_pc          <= r_fetch_pc;
              r_state       <= S_OUT;
              r_instr_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.flush) begin
            r_fetch_pc    <= w_flush_tgt;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
            r_mem_req     <= 1'b1;
          end else if (bus.instr_ready) begin
            r_fetch_pc    <= w_tgt;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
            r_mem_req     <= 1'b1;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: ;
`endif
        default: begin
          r_state       <= S_IDLE;
          r_mem_req     <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_fetch_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: responding memory model plus a scoreboard of
// expected {pc, instr} pairs pushed when a fetch is set up and popped when
// decode sees the instruction.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_err;
`endif

  fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];

  // memory model controls
  logic        gnt_en   = 1'b1;
  int          lat      = 1;
  logic        ovr_en   = 1'b0;
  logic [31:0] ovr_data = '0;
  logic        pend     = 1'b0;
  int          cnt      = 0;
  logic [31:0] paddr    = '0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
  endfunction

  // Memory: grants while enabled and idle, returns data `lat` cycles later.
  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        pend           = 1'b0;
      end else begin
        bus.mem_rvalid = 1'b0;
        if (pend) begin
          if (cnt <= 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = ovr_en ? ovr_data : mdata(paddr);
            ovr_en         = 1'b0;
            pend           = 1'b0;
          end else cnt--;
        end
        bus.mem_gnt = 1'b0;
        if (bus.mem_req && gnt_en && !pend) begin
          bus.mem_gnt = 1'b1;
          pend        = 1'b1;
          cnt         = lat;
          paddr       = bus.mem_addr;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid === 1'b1) break;
      step();
    end
    chk("valid_wait", {31'b0, bus.instr_valid}, 32'd1);
  endtask

  // Compare the presented instruction against the scoreboard head.
  task automatic pop_cmp();
    logic [63:0] e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL sb_empty: observed pc %h expected a queued entry", bus.pc);
    end else begin
      e = sb.pop_front();
      chk("instr", bus.instr, e[31:0]);
      chk("pc",    bus.pc,    e[63:32]);
    end
  endtask

  task automatic accept(input logic src, input logic [31:0] imm);
    wait_valid();
    pop_cmp();
    bus.instr_ready = 1'b1; bus.pc_src = src; bus.imm_op = imm;
    step();
    bus.instr_ready = 1'b0; bus.pc_src = 1'b0; bus.imm_op = '0;
  endtask

  task automatic push(input logic [31:0] a);
    sb.push_back({a, mdata(a)});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_ready = 1'b0; bus.pc_src = 1'b0; bus.imm_op = '0;
    bus.flush = 1'b0; bus.flush_addr = '0;
    step(); step();
    chk("rst_req",   {31'b0, bus.mem_req},     32'd0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc",    bus.pc,    32'h0);
    rst = 1'b0;

    // first fetch: req one cycle after release, valid two cycles after req
    step();
    chk("first_req",  {31'b0, bus.mem_req}, 32'd1);
    chk("first_addr", bus.mem_addr, 32'h0);
    push(32'h0);
    step();
    chk("wait_valid0", {31'b0, bus.instr_valid}, 32'd0);
    step();
    chk("lat_valid", {31'b0, bus.instr_valid}, 32'd1);
    accept(1'b0, 32'h0);
    chk("seq_addr", bus.mem_addr, 32'h4);

    // flush in REQ without grant: address changes, request stays up
    gnt_en = 1'b0;
    bus.flush = 1'b1; bus.flush_addr = 32'h10;
    step();
    bus.flush = 1'b0;
    chk("fl_req_req",  {31'b0, bus.mem_req}, 32'd1);
    chk("fl_req_addr", bus.mem_addr, 32'h10);
    step();
    chk("fl_req_hold", bus.mem_addr, 32'h10);
    gnt_en = 1'b1;

    // branches
    push(32'h10);
    accept(1'b1, 32'hFFFF_FFF8);
    chk("br_back", bus.mem_addr, 32'h8);
    push(32'h8);
    accept(1'b1, 32'h8);
    chk("br_fwd8", bus.mem_addr, 32'h10);
    push(32'h10);
    accept(1'b1, 32'hC);
    chk("br_fwdC", bus.mem_addr, 32'h1C);

    // backpressure
    push(32'h1C);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("bp_pc",    bus.pc,    32'h1C);
      chk("bp_instr", bus.instr, mdata(32'h1C));
      chk("bp_req",   {31'b0, bus.mem_req}, 32'd0);
      step();
    end
    accept(1'b0, 32'h0);
    chk("bp_next", bus.mem_addr, 32'h20);

    // flush in WAIT, stale response arrives later and is dropped
    lat = 3; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    step();
    chk("fw_wait_req", {31'b0, bus.mem_req}, 32'd0);
    bus.flush = 1'b1; bus.flush_addr = 32'h200;
    step();
    bus.flush = 1'b0;
    step();
    chk("fw_valid0", {31'b0, bus.instr_valid}, 32'd0);
    chk("fw_req0",   {31'b0, bus.mem_req},     32'd0);
    step();
    lat = 1;
    chk("fw_valid1", {31'b0, bus.instr_valid}, 32'd0);
    chk("fw_req1",   {31'b0, bus.mem_req},     32'd1);
    chk("fw_addr",   bus.mem_addr, 32'h200);
    push(32'h200);
    wait_valid();
    pop_cmp();

    // flush together with ready + taken branch in OUT
    bus.instr_ready = 1'b1; bus.pc_src = 1'b1; bus.imm_op = 32'h40;
    bus.flush = 1'b1; bus.flush_addr = 32'h300;
    step();
    bus.instr_ready = 1'b0; bus.pc_src = 1'b0; bus.imm_op = '0; bus.flush = 1'b0;
    chk("fo_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("fo_req",   {31'b0, bus.mem_req},     32'd1);
    chk("fo_addr",  bus.mem_addr, 32'h300);
    push(32'h300);
    accept(1'b0, 32'h0);
    chk("fo_next", bus.mem_addr, 32'h304);

    // flush in REQ with grant, then wrap-around
    bus.flush = 1'b1; bus.flush_addr = 32'hFFFF_FFFC;
    step();
    bus.flush = 1'b0;
    chk("fg_wait_req", {31'b0, bus.mem_req}, 32'd0);
    step();
    chk("fg_addr", bus.mem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    accept(1'b0, 32'h0);
    chk("wrap_addr", bus.mem_addr, 32'h0);

    push(32'h0);
    accept(1'b1, 32'h2);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_err",   {31'b0, misalign_err},    32'd1);
    chk("mis_req",   {31'b0, bus.mem_req},     32'd0);
    chk("mis_valid", {31'b0, bus.instr_valid}, 32'd0);
    bus.flush = 1'b1; bus.flush_addr = 32'h100;
    step(); step();
    bus.flush = 1'b0;
    chk("halt_req",  {31'b0, bus.mem_req}, 32'd0);
    chk("halt_err",  {31'b0, misalign_err}, 32'd1);
`else
    chk("mis_req",  {31'b0, bus.mem_req}, 32'd1);
    chk("mis_addr", bus.mem_addr, 32'h0);
    bus.flush = 1'b1; bus.flush_addr = 32'h403;
    step();
    bus.flush = 1'b0;
    step();
    chk("misfl_addr", bus.mem_addr, 32'h400);
    push(32'h400);
    wait_valid();
    pop_cmp();
`endif

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("arst_req",   {31'b0, bus.mem_req},     32'd0);
    chk("arst_pc",    bus.pc,    32'h0);
    chk("arst_instr", bus.instr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("arst_err", {31'b0, misalign_err}, 32'd0);
`endif
    sb.delete();
    step(); step();
    rst = 1'b0;
    step();
    chk("rerun_addr", bus.mem_addr, 32'h0);
    chk("rerun_req",  {31'b0, bus.mem_req}, 32'd1);
    push(32'h0);
    accept(1'b0, 32'h0);
    chk("rerun_next", bus.mem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
